dac_frame_serializer: RTL and testbench

- Parametrised frame serializer in the clk_dac0 domain, between the TX sample FIFO (first-word-fall-through read side) and the DAC DDR output primitives.
- Unpacks one FIFO word of NCH channel samples into NCH consecutive clk_dac0 slots.
- Splits each sample into the rising-edge (D0) and falling-edge (D1) lane halves and generates the frame marker.
- Adds what the previous DAC path lacked: empty-aware FIFO reads, underrun handling (hold or zero) with a saturating counter, and clean start/stop on frame boundaries.

---
 rtl/dac_pkg.sv | 21 ++
 rtl/dac_frame_serializer_if.sv | 21 ++
 rtl/dac_frame_serializer_sat_counter.sv | 20 ++
 rtl/dac_frame_serializer.sv | 109 ++++++++++
 tb/tb_dac_frame_serializer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// Shared DAC/ADC framer definitions.
// State encoding and slot-width helper.
package dac_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int slot_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/dac_frame_serializer_if.sv
// FWFT FIFO read-side bundle.
// master = FIFO, slave = frame serializer.
interface dac_frame_serializer_if #(
  parameter int W = 32
);
  logic [W-1:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_rd_en;

  modport master (
    output fifo_dout,
    output fifo_empty,
    input  fifo_rd_en
  );

  modport slave (
    input  fifo_dout,
    input  fifo_empty,
    output fifo_rd_en
  );
endinterface

// File: rtl/dac_frame_serializer_sat_counter.sv
// Saturating event counter.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dac_frame_serializer.sv
// FIFO word -> DDR lane serializer for the DAC.
// One word per frame, one channel sample per slot.
module dac_frame_serializer
  import dac_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int SAMPLE_W = 16,
  parameter int LANE_W   = 8,
  parameter int CNT_W    = 16
) (
  input  logic                 clk_dac0,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 underrun_zero,
  dac_frame_serializer_if.slave fifo,
  output logic [LANE_W-1:0]    ddr_d0,
  output logic [LANE_W-1:0]    ddr_d1,
  output logic                 frame,
  output logic                 active,
  output logic [CNT_W-1:0]     underrun_cnt
);

  localparam int SW = slot_w(NCH);
  localparam int WW = NCH * SAMPLE_W;
  localparam logic [SW-1:0] LAST = SW'(NCH - 1);

  state_t        state, state_n;
  logic [SW-1:0] slot, slot_n;
  logic [WW-1:0] word_q, word_n;
  logic          rd, uflow, last;
  logic [SAMPLE_W-1:0] sample;

  assign last   = (slot == LAST);
  assign sample = word_q[slot*SAMPLE_W +: SAMPLE_W];

  assign fifo.fifo_rd_en = rd && !reset;

  always_comb begin
    state_n = state;
    slot_n  = slot;
    word_n  = word_q;
    rd      = 1'b0;
    uflow   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable && !fifo.fifo_empty) begin
          rd      = 1'b1;
          word_n  = fifo.fifo_dout;
          slot_n  = '0;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!last) begin
          slot_n = slot + 1'b1;
        end else begin
          slot_n = '0;
          // stop wins over underrun so a clean stop never counts
          if (!enable) begin
            state_n = ST_IDLE;
            word_n  = '0;
          end else if (!fifo.fifo_empty) begin
            rd     = 1'b1;
            word_n = fifo.fifo_dout;
          end else begin
            uflow = 1'b1;
            if (underrun_zero) word_n = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_dac0) begin
    if (reset) begin
      state  <= ST_IDLE;
      slot   <= '0;
      word_q <= '0;
      ddr_d0 <= '0;
      ddr_d1 <= '0;
      frame  <= 1'b0;
      active <= 1'b0;
    end else begin
      state  <= state_n;
      slot   <= slot_n;
      word_q <= word_n;
      active <= (state_n == ST_RUN);
      if (state == ST_RUN) begin
        ddr_d0 <= sample[SAMPLE_W-1:LANE_W];
        ddr_d1 <= sample[LANE_W-1:0];
        frame  <= (slot == '0);
      end else begin
        ddr_d0 <= '0;
        ddr_d1 <= '0;
        frame  <= 1'b0;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_underrun_cnt (
    .clk  (clk_dac0),
    .reset(reset),
    .inc  (uflow),
    .count(underrun_cnt)
  );

endmodule

// File: tb/tb_dac_frame_serializer.sv
// Bench for dac_frame_serializer (NCH=2, 16-bit samples, 4-bit counter).
// Per-cycle output expectations are queued by each scenario.
module tb_dac_frame_serializer;

  localparam logic [31:0] WA = 32'h44332211;
  localparam logic [31:0] WB = 32'h88776655;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       frame;
    logic       active;
  } exp_t;

  logic       clk_dac0;
  logic       reset;
  logic       enable;
  logic       underrun_zero;
  logic [7:0] ddr_d0;
  logic [7:0] ddr_d1;
  logic       frame;
  logic       active;
  logic [3:0] underrun_cnt;

  dac_frame_serializer_if #(.W(32)) fifo_bus ();

  dac_frame_serializer #(
    .NCH(2),
    .SAMPLE_W(16),
    .LANE_W(8),
    .CNT_W(4)
  ) dut (
    .clk_dac0     (clk_dac0),
    .reset        (reset),
    .enable       (enable),
    .underrun_zero(underrun_zero),
    .fifo         (fifo_bus),
    .ddr_d0       (ddr_d0),
    .ddr_d1       (ddr_d1),
    .frame        (frame),
    .active       (active),
    .underrun_cnt (underrun_cnt)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          step    = 0;
  logic [31:0] fq[$];
  exp_t        exp_q[$];
  exp_t        e;

  initial begin
    clk_dac0 = 1'b0;
    forever #5 clk_dac0 = ~clk_dac0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  // scoreboard: one queued expectation per clock
  always @(posedge clk_dac0) begin
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({ddr_d0, ddr_d1, frame, active} !==
          {e.d0, e.d1, e.frame, e.active}) begin
        n_fail++;
        $display("FAIL out step %0d: got d0=%h d1=%h fr=%b act=%b, want d0=%h d1=%h fr=%b act=%b",
                 step, ddr_d0, ddr_d1, frame, active,
                 e.d0, e.d1, e.frame, e.active);
      end
      step++;
    end
  end

  task automatic drive_fifo();
    fifo_bus.fifo_empty = (fq.size() == 0);
    fifo_bus.fifo_dout  = (fq.size() > 0) ? fq[0] : 32'h0;
  endtask

  task automatic expect_out(input logic [7:0] d0, input logic [7:0] d1,
                            input logic f, input logic a);
    exp_t x;
    x.d0 = d0; x.d1 = d1; x.frame = f; x.active = a;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    logic rd;
    #1;
    rd = fifo_bus.fifo_rd_en;
    @(posedge clk_dac0);
    #1;
    if (rd && fq.size() > 0) void'(fq.pop_front());
    drive_fifo();
    @(negedge clk_dac0);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; underrun_zero = 1'b0;
    fq.delete(); fq.push_back(WA); drive_fifo();
    repeat (3) expect_out(8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (fifo_bus.fifo_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rd_en cyc %0d: got %b want 0", i, fifo_bus.fifo_rd_en);
      end
      tick();
    end
    n_tests++;
    if (underrun_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", underrun_cnt);
    end
    fq.delete(); drive_fifo();
    enable = 1'b0; reset = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    fq.push_back(WA); fq.push_back(WB); drive_fifo();
    enable = 1'b1; underrun_zero = 1'b0;
    #1;
    n_tests++;
    if (fifo_bus.fifo_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_rd_t0: got %b want 1", fifo_bus.fifo_rd_en);
    end
    expect_out(8'h00, 8'h00, 1'b0, 1'b1);
    expect_out(8'h22, 8'h11, 1'b1, 1'b1);
    expect_out(8'h44, 8'h33, 1'b0, 1'b1);
    expect_out(8'h66, 8'h55, 1'b1, 1'b1);
    expect_out(8'h88, 8'h77, 1'b0, 1'b0);
    expect_out(8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    #1;
    n_tests++;
    if (fifo_bus.fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_rd_t1: got %b want 0", fifo_bus.fifo_rd_en);
    end
    tick();
    #1;
    n_tests++;
    if (fifo_bus.fifo_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_rd_t2: got %b want 1", fifo_bus.fifo_rd_en);
    end
    tick();
    enable = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (fq.size() != 0 || underrun_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL stream_end: got fifo=%0d cnt=%0d want fifo=0 cnt=0",
               fq.size(), underrun_cnt);
    end
  endtask

  task automatic test_underrun_hold();
    fq.push_back(WA); drive_fifo();
    enable = 1'b1; underrun_zero = 1'b0;
    expect_out(8'h00, 8'h00, 1'b0, 1'b1);
    for (int p = 2; p <= 10; p++) begin
      if (p % 2 == 0) expect_out(8'h22, 8'h11, 1'b1, 1'b1);
      else            expect_out(8'h44, 8'h33, 1'b0, 1'b1);
    end
    expect_out(8'h44, 8'h33, 1'b0, 1'b0);
    expect_out(8'h00, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_tests++;
      if (underrun_cnt !== 4'(k)) begin
        n_fail++;
        $display("FAIL hold_cnt frame %0d: got %0d want %0d", k, underrun_cnt, k);
      end
      if (k < 4) tick();
    end
    enable = 1'b0;
    tick(); tick();
    n_tests++;
    if (underrun_cnt !== 4'd4) begin
      n_fail++;
      $display("FAIL hold_cnt_stop: got %0d want 4", underrun_cnt);
    end
    tick();
  endtask

  task automatic test_underrun_zero();
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests++;
    if (underrun_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL zero_cnt_cleared: got %0d want 0", underrun_cnt);
    end
    fq.push_back(WA); drive_fifo();
    enable = 1'b1; underrun_zero = 1'b1;
    expect_out(8'h00, 8'h00, 1'b0, 1'b1);
    expect_out(8'h22, 8'h11, 1'b1, 1'b1);
    expect_out(8'h44, 8'h33, 1'b0, 1'b1);
    expect_out(8'h00, 8'h00, 1'b1, 1'b1);
    expect_out(8'h00, 8'h00, 1'b0, 1'b1);
    expect_out(8'h00, 8'h00, 1'b1, 1'b1);
    expect_out(8'h00, 8'h00, 1'b0, 1'b1);
    expect_out(8'h66, 8'h55, 1'b1, 1'b1);
    expect_out(8'h88, 8'h77, 1'b0, 1'b0);
    expect_out(8'h00, 8'h00, 1'b0, 1'b0);
    repeat (5) tick();
    n_tests++;
    if (underrun_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL zero_cnt: got %0d want 2", underrun_cnt);
    end
    fq.push_back(WB); drive_fifo();
    #1;
    n_tests++;
    if (fifo_bus.fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_rd_slot0: got %b want 0", fifo_bus.fifo_rd_en);
    end
    tick();
    #1;
    n_tests++;
    if (fifo_bus.fifo_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_rd_refill: got %b want 1", fifo_bus.fifo_rd_en);
    end
    tick();
    n_tests++;
    if (underrun_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL zero_cnt_refill: got %0d want 2", underrun_cnt);
    end
    enable = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_stop();
    fq.push_back(WA); fq.push_back(WB); drive_fifo();
    enable = 1'b1; underrun_zero = 1'b0;
    expect_out(8'h00, 8'h00, 1'b0, 1'b1);
    expect_out(8'h22, 8'h11, 1'b1, 1'b1);
    expect_out(8'h44, 8'h33, 1'b0, 1'b0);
    expect_out(8'h00, 8'h00, 1'b0, 1'b0);
    expect_out(8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    enable = 1'b0;
    tick();
    #1;
    n_tests++;
    if (fifo_bus.fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_rd_last: got %b want 0", fifo_bus.fifo_rd_en);
    end
    tick();
    #1;
    n_tests++;
    if (fifo_bus.fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_rd_idle: got %b want 0", fifo_bus.fifo_rd_en);
    end
    tick(); tick();
    n_tests++;
    if (fq.size() != 1) begin
      n_fail++;
      $display("FAIL stop_fifo_kept: got %0d words want 1", fq.size());
    end
    fq.delete(); drive_fifo();
  endtask

  task automatic test_saturation();
    reset = 1'b1; tick(); reset = 1'b0;
    fq.push_back(WA); drive_fifo();
    enable = 1'b1; underrun_zero = 1'b1;
    expect_out(8'h00, 8'h00, 1'b0, 1'b1);
    expect_out(8'h22, 8'h11, 1'b1, 1'b1);
    expect_out(8'h44, 8'h33, 1'b0, 1'b1);
    for (int p = 4; p <= 41; p++)
      expect_out(8'h00, 8'h00, (p % 2 == 0), 1'b1);
    expect_out(8'h00, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_tests++;
      if (underrun_cnt !== 4'((k > 15) ? 15 : k)) begin
        n_fail++;
        $display("FAIL sat_cnt frame %0d: got %0d want %0d",
                 k, underrun_cnt, (k > 15) ? 15 : k);
      end
      if (k < 20) tick();
    end
    reset = 1'b1;
    fq.push_back(WB); drive_fifo();
    #1;
    n_tests++;
    if (fifo_bus.fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_rd_in_reset: got %b want 0", fifo_bus.fifo_rd_en);
    end
    tick();
    n_tests++;
    if (underrun_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_cnt_reset: got %0d want 0", underrun_cnt);
    end
    reset = 1'b0; enable = 1'b0;
    fq.delete(); drive_fifo();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    underrun_zero = 1'b0;
    drive_fifo();
    test_reset();
    test_stream();
    test_underrun_hold();
    test_underrun_zero();
    test_stop();
    test_saturation();
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
